counter_seq_ctrl: RTL
=====================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 start  in  1  begin a count sequence; honoured only in IDLE.
REQ-005 pause  in  1  while high in RUN, count holds.
REQ-006 abort  in  1  immediate return to IDLE from any state.
REQ-007 term  in  WIDTH  terminal count; sampled only when start is accepted.
REQ-008 auto_reload  in  1  1 = restart on terminal count; 0 = one-shot; sampled with term.
REQ-009 dir  in  1  0 = up, 1 = down; present only when DIR_EN is defined; sampled with term.
REQ-010 q  out  WIDTH  current count, registered.
REQ-011 busy  out  1  high exactly while state is RUN.
REQ-012 done  out  1  registered one-cycle pulse on terminal count.
REQ-013 reloads  out  4  number of auto-reload wraps since start, saturating at 15.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE, with a registered state register.
REQ-015 IDLE + start (no abort) SHALL move to RUN next edge, latch term/auto_reload/dir, load q with 0 (up) or term (down), and clear reloads.
REQ-016 start SHALL be ignored in RUN and DONE.
REQ-017 In RUN with pause=0 and q != end value (term up, 0 down), q SHALL step by one per cycle, modulo 2^WIDTH.
REQ-018 In RUN with pause=1, q, state and reloads SHALL hold and done SHALL stay 0.
REQ-019 In RUN, pause=0 and q equal to the end value, done SHALL be 1 on the next cycle.
REQ-020 On that terminal edge with auto_reload=1, q SHALL reload to its start value, state SHALL remain RUN, reloads SHALL increment (saturating at 15).
REQ-021 On that terminal edge with auto_reload=0, q SHALL hold the end value and state SHALL move to DONE.
REQ-022 DONE SHALL move to IDLE on the next edge, with q cleared to 0; done is therefore one cycle wide.
REQ-023 Latched term=0 (up) SHALL terminate on the first RUN cycle; term=15 SHALL give 16 RUN cycles per sequence.
REQ-024 abort SHALL have priority over start and pause: next edge state=IDLE, q=0, done=0, reloads holds its value.
REQ-025 Simultaneous abort and terminal count SHALL produce no done pulse.

Reset
REQ-026 rst SHALL take effect only on a rising clk edge and have priority over all other inputs.
REQ-027 After reset: state IDLE, q=0, busy=0, done=0, reloads=0, latched term/auto_reload/dir=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the sequence without a done pulse.

Configuration
REQ-029 Macro COUNTER_SEQ_DIR_EN SHALL, when defined, add the dir port and down-count behaviour.
REQ-030 Without COUNTER_SEQ_DIR_EN, the dir port SHALL be absent and counting SHALL be up-only, with identical timing.

Structure
REQ-031 Shared package counter_seq_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the reloads saturation constant 15.
REQ-032 Count datapath SHALL be a separate sub-module cnt_core (enable, load, load value, direction, q); counter_seq_ctrl SHALL hold only the FSM and control registers.

Verification
REQ-033 Reset then start with term=5, auto_reload=0 -> busy for 6 cycles, q=0..5, done high one cycle after q=5, then IDLE with q=0.
REQ-034 term=3, auto_reload=1, run 12 cycles -> done every 4 cycles, q wraps 3->0, reloads=3.
REQ-035 term=9 and pause high for 3 cycles at q=4 -> q holds 4 for 3 cycles, done delayed by exactly 3 cycles.
REQ-036 Abort at q=7 with term=10 -> next cycle IDLE, q=0, no done pulse; start on the same cycle as abort is ignored.
REQ-037 With COUNTER_SEQ_DIR_EN defined: dir=1, term=4 -> q=4,3,2,1,0, then done.
REQ-038 term=0 -> done one cycle after start acceptance; reloads saturates at 15 after 20 wraps with term=0, auto_reload=1.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] RELOADS_MAX = 4'd15;

endpackage

// File: rtl/counter_seq_ctrl_cnt_core.sv
// Count datapath: load has priority over stepping; step is +1 or -1.
module cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (en_i) begin
      q_q <= dir_i ? q_q - WIDTH'(1) : q_q + WIDTH'(1);
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Counter sequencer FSM and control registers.
// Define COUNTER_SEQ_DIR_EN to add the dir port and down-counting.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] term,
  input  logic             auto_reload,
`ifdef COUNTER_SEQ_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [3:0]       reloads
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             ar_q, ar_d;
  logic             dir_q, dir_d;
  logic [3:0]       reloads_q, reloads_d;
  logic             done_q, done_d;

  logic             dir_in;
  logic             cnt_en, cnt_ld;
  logic [WIDTH-1:0] cnt_ld_val;
  logic [WIDTH-1:0] start_val, end_val;

`ifdef COUNTER_SEQ_DIR_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  assign start_val = dir_q ? term_q : '0;
  assign end_val   = dir_q ? '0 : term_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      term_q    <= '0;
      ar_q      <= 1'b0;
      dir_q     <= 1'b0;
      reloads_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      term_q    <= term_d;
      ar_q      <= ar_d;
      dir_q     <= dir_d;
      reloads_q <= reloads_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    ar_d       = ar_q;
    dir_d      = dir_q;
    reloads_d  = reloads_q;
    done_d     = 1'b0;
    cnt_en     = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    if (abort) begin
      state_d = IDLE;
      cnt_ld  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = RUN;
            term_d     = term;
            ar_d       = auto_reload;
            dir_d      = dir_in;
            reloads_d  = '0;
            cnt_ld     = 1'b1;
            cnt_ld_val = dir_in ? term : '0;
          end
        end
        RUN: begin
          if (!pause) begin
            if (q == end_val) begin
              done_d = 1'b1;
              if (ar_q) begin
                cnt_ld     = 1'b1;
                cnt_ld_val = start_val;
                if (reloads_q != RELOADS_MAX)
                  reloads_d = reloads_q + 4'd1;
              end else begin
                state_d = DONE;
              end
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_ld  = 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_ld  = 1'b1;
        end
      endcase
    end
  end

  cnt_core #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en_i      (cnt_en),
    .load_i    (cnt_ld),
    .load_val_i(cnt_ld_val),
    .dir_i     (dir_q),
    .q_o       (q)
  );

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign reloads = reloads_q;

endmodule
